// File: rtl/pixel_pack_pkg.sv
// pixel_pack shared types: widths, SDRAM word pair and RGB packing.
package pixel_pack_pkg;

   localparam int PIX_W  = 12;
   localparam int WORD_W = 16;

   typedef struct packed {
      logic [WORD_W-1:0] word1;
      logic [WORD_W-1:0] word2;
   } sdram_pair_t;

   // word1 carries G-high/B, word2 carries G-low/R; 2 LSBs of each are lost
   function automatic sdram_pair_t pack_rgb(
      input logic [PIX_W-1:0] r,
      input logic [PIX_W-1:0] g,
      input logic [PIX_W-1:0] b
   );
      sdram_pair_t p;
      p.word1 = {1'b0, g[11:7], b[11:2]};
      p.word2 = {1'b0, g[6:2],  r[11:2]};
      return p;
   endfunction

endpackage

// File: rtl/pixel_pack_if.sv
// Pixel stream in, SDRAM write port out.
interface pixel_pack_if;
   import pixel_pack_pkg::*;

   logic [PIX_W-1:0]  iRed;
   logic [PIX_W-1:0]  iGreen;
   logic [PIX_W-1:0]  iBlue;
   logic              iDVAL;
   logic              iWR_FULL;
   logic [WORD_W-1:0] oWR1_DATA;
   logic [WORD_W-1:0] oWR2_DATA;
   logic              oWR_EN;

   modport slave (
      input  iRed, iGreen, iBlue, iDVAL, iWR_FULL,
      output oWR1_DATA, oWR2_DATA, oWR_EN
   );

   modport master (
      output iRed, iGreen, iBlue, iDVAL, iWR_FULL,
      input  oWR1_DATA, oWR2_DATA, oWR_EN
   );

endinterface

// File: rtl/pixel_pack_sync_fifo.sv
// Synchronous FIFO with explicit level; a push into a full FIFO is
// accepted only alongside a pop.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [WIDTH-1:0]       i_wdata,
   output logic [WIDTH-1:0]       o_rdata,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_level == (AW+1)'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_rdata   = r_mem[r_rptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_wdata;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_do_push && !w_do_pop)
            r_level <= r_level + 1'b1;
         else if (!w_do_push && w_do_pop)
            r_level <= r_level - 1'b1;
      end
   end

endmodule

// File: rtl/pixel_pack.sv
// Packs RGB pixels into SDRAM word pairs through a small FIFO.
// Define PIXEL_PACK_FRAME_CNT_EN to build the per-frame pixel counter.
module pixel_pack
   import pixel_pack_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int FRAME_PIXELS = 307200
) (
   input  logic                   iCLK,
   input  logic                   iRST,
   input  logic                   iFRAME_CLR,
   pixel_pack_if.slave            pix,
   output logic [$clog2(DEPTH):0] oLEVEL,
   output logic                   oOVERFLOW,
   output logic                   oFRAME_DONE,
   output logic [19:0]            oPIX_CNT
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       FRAME_PIXELS < 1 || FRAME_PIXELS >= (1 << 20)) begin : g_bad_param
      $error("pixel_pack: illegal DEPTH or FRAME_PIXELS");
   end

   sdram_pair_t w_pack;
   sdram_pair_t w_head;
   sdram_pair_t r_pair;
   logic        r_wr_en;
   logic        r_ovf;
   logic        w_full;
   logic        w_empty;
   logic        w_pop;
   logic        w_push;
   logic        w_drop;

   assign w_pack = pack_rgb(pix.iRed, pix.iGreen, pix.iBlue);
   assign w_pop  = !w_empty && !pix.iWR_FULL;
   assign w_push = pix.iDVAL && (!w_full || w_pop);
   assign w_drop = pix.iDVAL && w_full && !w_pop;

   sync_fifo #(
      .WIDTH ($bits(sdram_pair_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (iCLK),
      .i_rst   (iRST),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_pack),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (oLEVEL)
   );

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_pair  <= '0;
         r_wr_en <= 1'b0;
      end else begin
         r_wr_en <= w_pop;
         if (w_pop) r_pair <= w_head;
      end
   end

   // a drop at the same edge as a clear must still be reported
   always_ff @(posedge iCLK) begin
      if (iRST)            r_ovf <= 1'b0;
      else if (w_drop)     r_ovf <= 1'b1;
      else if (iFRAME_CLR) r_ovf <= 1'b0;
   end

   assign pix.oWR1_DATA = r_pair.word1;
   assign pix.oWR2_DATA = r_pair.word2;
   assign pix.oWR_EN    = r_wr_en;
   assign oOVERFLOW     = r_ovf;

`ifdef PIXEL_PACK_FRAME_CNT_EN
   logic [19:0] r_cnt;
   logic [19:0] w_cnt_inc;
   logic        r_done;

   assign w_cnt_inc = r_cnt + 20'd1;

   // dropped pixels are counted too so frame alignment survives stalls
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (iFRAME_CLR) begin
            r_cnt <= {19'd0, pix.iDVAL};
         end else if (pix.iDVAL) begin
            if (w_cnt_inc == 20'(FRAME_PIXELS)) begin
               r_cnt  <= '0;
               r_done <= 1'b1;
            end else begin
               r_cnt <= w_cnt_inc;
            end
         end
      end
   end

   assign oFRAME_DONE = r_done;
   assign oPIX_CNT    = r_cnt;
`else
   assign oFRAME_DONE = 1'b0;
   assign oPIX_CNT    = '0;
`endif

endmodule

// File: doc/pixel_pack.md
# pixel_pack

Downstream stage of the image-processing pipeline. It takes the 12-bit RGB pixel stream and its data-valid strobe, and packs each pixel into the two 16-bit words the SDRAM write ports expect. A small FIFO absorbs short stalls from the SDRAM write FIFO. The block also flags dropped pixels and, optionally, counts pixels per frame.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- FRAME_PIXELS, 307200, pixels per frame (640x480); must be below 2^20.

Ports:
- iCLK  in  1  sole clock.
- iRST  in  1  synchronous, active-high reset.
- iRed  in  12  red component.
- iGreen  in  12  green component.
- iBlue  in  12  blue component.
- iDVAL  in  1  pixel valid for one cycle; there is no backpressure on this side.
- iWR_FULL  in  1  SDRAM write FIFO full; a pop is forbidden while it is high.
- iFRAME_CLR  in  1  single-cycle pulse that clears oOVERFLOW and the pixel count.
- oWR1_DATA  out  16  word {1'b0, G[11:7], B[11:2]}.
- oWR2_DATA  out  16  word {1'b0, G[6:2], R[11:2]}.
- oWR_EN  out  1  write strobe for both SDRAM ports, one cycle per pixel.
- oLEVEL  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the output register.
- oOVERFLOW  out  1  sticky flag: a pixel was dropped.
- oFRAME_DONE  out  1  one-cycle pulse at the end of each frame.
- oPIX_CNT  out  20  iDVAL count within the current frame.

## Operation
- **Packing:** combinational from the inputs. The packed 32-bit pair {word1, word2} is stored as one FIFO entry.
- **Push:** happens when iDVAL=1 and the FIFO is not full, or when iDVAL=1, the FIFO is full and a pop occurs at the same edge.
- **Drop:** iDVAL=1 while the FIFO is full and no pop occurs at that edge.
  - The pixel is discarded and FIFO state is unchanged.
  - oOVERFLOW is set at that edge.
- **Pop:** happens when the FIFO is not empty and iWR_FULL=0.
  - At that edge the head entry loads into oWR1_DATA/oWR2_DATA and oWR_EN is set to 1.
  - On an edge with no pop, oWR_EN returns to 0 and the data outputs hold their value.
- **oLEVEL:** updates with every push and pop. A simultaneous push and pop leaves it unchanged.
- **Read/write pointers:** wrap modulo DEPTH. Full means level = DEPTH; empty means level = 0.
- **oOVERFLOW:** cleared only by iRST or iFRAME_CLR. If a drop and iFRAME_CLR occur at the same edge, the drop wins and the flag reads 1.
- **Pixel counter:** counts every iDVAL cycle, including dropped pixels, so frame alignment is preserved.
  - When an increment reaches FRAME_PIXELS, the counter wraps to 0 and oFRAME_DONE pulses for one cycle.
  - If iFRAME_CLR coincides with iDVAL, the counter becomes 1.
- **Reset (iRST=1 at an edge):** sets all outputs, pointers, the level and counters to 0, and discards FIFO contents. A frame in flight is lost. Inputs are ignored for that cycle.

## Timing
- A pixel pushed into an empty FIFO at edge k is popped at edge k+1. oWR_EN is high in the cycle after edge k+1, so latency is 2 cycles.
- Throughput is one pixel per cycle while iWR_FULL=0.
- iWR_FULL is sampled combinationally at the pop edge, with no registered look-ahead.
- oFRAME_DONE is high in the cycle after the edge at which the final pixel of the frame is counted.
- All outputs are registered.

## Configuration
- Macro: PIXEL_PACK_FRAME_CNT_EN.
- **Defined:** the pixel counter, oFRAME_DONE and oPIX_CNT operate as described above.
- **Undefined:**
  - The counter logic is not synthesised.
  - oFRAME_DONE and oPIX_CNT are tied to 0.
  - iFRAME_CLR clears only oOVERFLOW.
- Packing, FIFO and overflow behaviour are identical in both builds.

## Structure
- **Package pixel_pack_pkg:**
  - Constants PIX_W=12 and WORD_W=16.
  - typedef sdram_pair_t, a packed struct {word1, word2}.
  - Function pack_rgb(r, g, b) returning sdram_pair_t.
- **Sub-module sync_fifo:** parameterised by width and DEPTH; provides push, pop, full, empty and level.
- **pixel_pack itself:** push/pop/drop control, the output register, the overflow flag and the counter.

## Test plan
- **Packing:** R=12'hFFF, G=12'h0F0, B=12'hABC, one iDVAL with iWR_FULL=0 -> two cycles later oWR_EN=1, oWR1_DATA=16'h06AF, oWR2_DATA=16'h73FF.
- **Stall and fill:** hold iWR_FULL=1 and send DEPTH pixels -> oLEVEL=DEPTH and oWR_EN=0. Release iWR_FULL -> DEPTH consecutive oWR_EN pulses, in order.
- **Drop:** FIFO full, iWR_FULL=1, one more iDVAL -> that pixel never appears at the output, oOVERFLOW=1, oLEVEL stays DEPTH. Then pulse iFRAME_CLR -> oOVERFLOW=0.
- **Simultaneous push and pop:** FIFO full, iWR_FULL=0, iDVAL=1 -> no drop, oLEVEL unchanged, pixel emitted later in order.
- **Frame count:** FRAME_PIXELS=16 and 16 iDVAL pulses -> oFRAME_DONE high for exactly one cycle after the 16th pulse, then oPIX_CNT=0. Repeat with the macro undefined -> outputs stay 0.
- **Mid-stream reset:** assert iRST with 3 entries queued -> next cycle oLEVEL=0, oWR_EN=0, data outputs 0, and no stale pixel is emitted afterwards.
